// File: rtl/sja1000_ctrl_module_if.sv
// Register-access channel between the SJA1000 sequencer and the bus-cycle engine.
`timescale 1ns/1ps
interface sja1000_ctrl_module_if;
    logic        sja_trig_o;
    logic [16:0] sja_cmd_o;
    logic [7:0]  sja_rd_data_i;
    logic        sja_rd_valid_i;

    modport master (output sja_trig_o, sja_cmd_o, input  sja_rd_data_i, sja_rd_valid_i);
    modport slave  (input  sja_trig_o, sja_cmd_o, output sja_rd_data_i, sja_rd_valid_i);
endinterface

// File: rtl/sja1000_ctrl_module.sv
// PeliCAN-mode SJA1000 sequencer: chip init, SR polling, single-frame TX and
// RX buffer draining, issued as {wr, addr, data} commands to the bus-cycle engine.
`timescale 1ns/1ps
module sja1000_ctrl_module #(
    parameter int          ACC_CYCLES  = 24,
    parameter int          POLL_CYCLES = 1000,
    parameter logic [7:0]  CDR_VAL     = 8'hC8,
    parameter logic [7:0]  BTR0_VAL    = 8'h00,
    parameter logic [7:0]  BTR1_VAL    = 8'h14,
    parameter logic [7:0]  OCR_VAL     = 8'h1A,
    parameter logic [31:0] ACR_VAL     = 32'h0,
    parameter logic [31:0] AMR_VAL     = 32'hFFFF_FFFF
) (
    input  logic                          sys_clk,
    input  logic                          sys_rstn,
    input  logic                          tx_req,
    input  logic [10:0]                   tx_id,
    input  logic [3:0]                    tx_dlc,
    input  logic [63:0]                   tx_data,
    output logic                          tx_ack,
    output logic                          tx_done,
    output logic                          rx_valid,
    output logic [10:0]                   rx_id,
    output logic [3:0]                    rx_dlc,
    output logic [63:0]                   rx_data,
    output logic                          init_done,
    sja1000_ctrl_module_if.master         sja
);
    localparam logic [2:0] ST_INIT = 3'd0, ST_IDLE = 3'd1, ST_POLL = 3'd2, ST_TX = 3'd3, ST_RX = 3'd4;
    localparam logic [4:0] INIT_LAST = 5'd14, INIT_RD = 5'd15, INIT_CHK = 5'd16;
    localparam int WIN_W  = $clog2(ACC_CYCLES + 1);
    localparam int POLL_W = $clog2(POLL_CYCLES + 1);

    logic [2:0]        r_state;
    logic [4:0]        r_step;
    logic [3:0]        r_idx;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [POLL_W-1:0] r_poll_cnt;
    logic [7:0]        r_rd_byte;
    logic              r_trig;
    logic [16:0]       r_cmd;
    logic              r_tx_pend, r_tx_ack, r_tx_done, r_rx_valid, r_init_done;
    logic [10:0]       r_tx_id, r_sh_id, r_rx_id;
    logic [3:0]        r_tx_dlc, r_sh_dlc, r_rx_dlc;
    logic [63:0]       r_tx_data, r_sh_data, r_rx_data;
    logic              w_slot;
    logic [63:0]       w_tx_shift;
    logic [3:0]        w_fi_dlc;

    function automatic logic [16:0] f_wr(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [16:0] f_rd(input logic [7:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    // Init write list as {addr, data}; step 14 (and beyond) is the MOD=08 leave-reset write.
    function automatic logic [15:0] f_init(input logic [4:0] idx);
        case (idx)
            5'd0:    return {8'h00, 8'h01};
            5'd1:    return {8'h1F, CDR_VAL};
            5'd2:    return {8'h06, BTR0_VAL};
            5'd3:    return {8'h07, BTR1_VAL};
            5'd4:    return {8'h08, OCR_VAL};
            5'd5:    return {8'h10, ACR_VAL[31:24]};
            5'd6:    return {8'h11, ACR_VAL[23:16]};
            5'd7:    return {8'h12, ACR_VAL[15:8]};
            5'd8:    return {8'h13, ACR_VAL[7:0]};
            5'd9:    return {8'h14, AMR_VAL[31:24]};
            5'd10:   return {8'h15, AMR_VAL[23:16]};
            5'd11:   return {8'h16, AMR_VAL[15:8]};
            5'd12:   return {8'h17, AMR_VAL[7:0]};
            5'd13:   return {8'h04, 8'h00};
            default: return {8'h00, 8'h08};
        endcase
    endfunction

    // A slot is the first cycle at which a new access may be issued; read results are consumed there.
    assign w_slot     = (r_win_cnt == '0) && !r_trig;
    assign w_tx_shift = r_tx_data << {r_idx[2:0], 3'b000};
    assign w_fi_dlc   = (r_rd_byte[3:0] > 4'd8) ? 4'd8 : r_rd_byte[3:0];

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_win_cnt <= '0;
            r_rd_byte <= '0;
        end else begin
            if (r_trig)                r_win_cnt <= WIN_W'(ACC_CYCLES - 2);
            else if (r_win_cnt != '0) r_win_cnt <= r_win_cnt - WIN_W'(1);
            if (sja.sja_rd_valid_i && !w_slot) r_rd_byte <= sja.sja_rd_data_i;
            else if (r_trig)                   r_rd_byte <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state     <= ST_INIT;
            r_step      <= '0;
            r_idx       <= '0;
            r_poll_cnt  <= '0;
            r_trig      <= 1'b0;
            r_cmd       <= '0;
            r_tx_pend   <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_tx_done   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_init_done <= 1'b0;
            r_tx_id     <= '0;
            r_tx_dlc    <= '0;
            r_tx_data   <= '0;
            r_sh_id     <= '0;
            r_sh_dlc    <= '0;
            r_sh_data   <= '0;
            r_rx_id     <= '0;
            r_rx_dlc    <= '0;
            r_rx_data   <= '0;
        end else begin
            r_trig     <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_INIT: if (w_slot) begin
                    if (r_step <= INIT_LAST) begin
                        r_trig <= 1'b1; r_cmd <= {1'b1, f_init(r_step)}; r_step <= r_step + 5'd1;
                    end else if (r_step == INIT_RD) begin
                        r_trig <= 1'b1; r_cmd <= f_rd(8'h00); r_step <= INIT_CHK;
                    end else if (r_rd_byte[0]) begin
                        r_trig <= 1'b1; r_cmd <= f_wr(8'h00, 8'h08); r_step <= INIT_RD;
                    end else begin
                        r_init_done <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_poll_cnt  <= POLL_W'(POLL_CYCLES - 1);
                    end
                end
                ST_IDLE: begin
                    if (tx_req && !r_tx_pend) begin
                        r_tx_pend <= 1'b1;
                        r_tx_ack  <= 1'b1;
                        r_tx_id   <= tx_id;
                        r_tx_dlc  <= (tx_dlc > 4'd8) ? 4'd8 : tx_dlc;
                        r_tx_data <= tx_data;
                    end
                    if (r_poll_cnt == '0) begin
                        r_state <= ST_POLL;
                        r_step  <= '0;
                    end else begin
                        r_poll_cnt <= r_poll_cnt - POLL_W'(1);
                    end
                end
                ST_POLL: if (w_slot) begin
                    if (r_step == 5'd0) begin
                        r_trig <= 1'b1; r_cmd <= f_rd(8'h02); r_step <= 5'd1;
                    end else if (r_rd_byte[0]) begin
                        r_state <= ST_RX; r_step <= '0;
                    end else if (r_rd_byte[2] && r_tx_pend) begin
                        r_state <= ST_TX; r_step <= '0;
                    end else begin
                        r_state <= ST_IDLE; r_poll_cnt <= POLL_W'(POLL_CYCLES - 1);
                    end
                end
                ST_TX: if (w_slot) begin
                    r_trig <= 1'b1;
                    case (r_step)
                        5'd0: begin r_cmd <= f_wr(8'h10, {4'b0, r_tx_dlc}); r_step <= 5'd1; end
                        5'd1: begin r_cmd <= f_wr(8'h11, r_tx_id[10:3]);    r_step <= 5'd2; end
                        5'd2: begin
                            r_cmd  <= f_wr(8'h12, {r_tx_id[2:0], 5'b0});
                            r_idx  <= '0;
                            r_step <= 5'd3;
                        end
                        default: if (r_idx < r_tx_dlc) begin
                            r_cmd <= f_wr(8'h13 + {4'b0, r_idx}, w_tx_shift[63:56]);
                            r_idx <= r_idx + 4'd1;
                        end else begin
                            r_cmd      <= f_wr(8'h01, 8'h01);
                            r_tx_done  <= 1'b1;
                            r_tx_pend  <= 1'b0;
                            r_state    <= ST_IDLE;
                            r_poll_cnt <= POLL_W'(POLL_CYCLES - 1);
                        end
                    endcase
                end
                ST_RX: begin
                    if (r_step == 5'd5) begin
                        // Runs in the CMR trigger cycle so rx_valid lands one cycle later.
                        r_rx_valid <= 1'b1;
                        r_rx_id    <= r_sh_id;
                        r_rx_dlc   <= r_sh_dlc;
                        r_rx_data  <= r_sh_data;
                        r_state    <= ST_POLL;
                        r_step     <= '0;
                    end else if (r_step == 5'd6) begin
                        r_state <= ST_POLL;
                        r_step  <= '0;
                    end else if (w_slot) begin
                        r_trig <= 1'b1;
                        case (r_step)
                            5'd0: begin r_cmd <= f_rd(8'h10); r_step <= 5'd1; end
                            5'd1: begin
                                r_sh_dlc  <= w_fi_dlc;
                                r_sh_data <= '0;
                                if (r_rd_byte[7]) begin
                                    r_cmd <= f_wr(8'h01, 8'h04); r_step <= 5'd6;
                                end else begin
                                    r_cmd <= f_rd(8'h11); r_step <= 5'd2;
                                end
                            end
                            5'd2: begin
                                r_sh_id[10:3] <= r_rd_byte;
                                r_cmd <= f_rd(8'h12); r_step <= 5'd3;
                            end
                            5'd3: begin
                                r_sh_id[2:0] <= r_rd_byte[7:5];
                                r_idx        <= '0;
                                if (r_sh_dlc == 4'd0) begin
                                    r_cmd <= f_wr(8'h01, 8'h04); r_step <= 5'd5;
                                end else begin
                                    r_cmd <= f_rd(8'h13); r_step <= 5'd4;
                                end
                            end
                            default: begin
                                r_sh_data <= r_sh_data | ({r_rd_byte, 56'd0} >> {r_idx[2:0], 3'b000});
                                r_idx     <= r_idx + 4'd1;
                                if (r_idx + 4'd1 == r_sh_dlc) begin
                                    r_cmd <= f_wr(8'h01, 8'h04); r_step <= 5'd5;
                                end else begin
                                    r_cmd <= f_rd(8'h14 + {4'b0, r_idx});
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_step  <= '0;
                end
            endcase
        end
    end

    assign tx_ack         = r_tx_ack;
    assign tx_done        = r_tx_done;
    assign rx_valid       = r_rx_valid;
    assign rx_id          = r_rx_id;
    assign rx_dlc         = r_rx_dlc;
    assign rx_data        = r_rx_data;
    assign init_done      = r_init_done;
    assign sja.sja_trig_o = r_trig;
    assign sja.sja_cmd_o  = r_cmd;
endmodule

// File: tb/tb_sja1000_ctrl_module.sv
// Directed bench for sja1000_ctrl_module with a behavioural bus-cycle engine and chip register model.
`timescale 1ns/1ps
module tb_sja1000_ctrl_module;
    localparam int ACC  = 24;
    localparam int POLL = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        tx_req = 1'b0;
    logic [10:0] tx_id = '0;
    logic [3:0]  tx_dlc = '0;
    logic [63:0] tx_data = '0;
    logic        tx_ack, tx_done, rx_valid, init_done;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;

    sja1000_ctrl_module_if sja();

    sja1000_ctrl_module #(.ACC_CYCLES(ACC), .POLL_CYCLES(POLL)) u_dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn),
        .tx_req(tx_req), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
        .tx_ack(tx_ack), .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_id(rx_id), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .init_done(init_done), .sja(sja)
    );

    always #5 sys_clk = ~sys_clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [16:0] log_cmd[$];
    int          log_cyc[$];
    int          mod_ones = 0;
    logic [7:0]  sr_val = 8'h00;
    logic [7:0]  rx_mem[16];
    int          n_ack = 0, n_done = 0, n_rxv = 0, n_cmr4 = 0;
    int          done_cyc = 0, rxv_cyc = 0, cmr4_cyc = 0;
    logic        done_on_cmr = 1'b0;
    logic [10:0] cap_id;
    logic [3:0]  cap_dlc;
    logic [63:0] cap_data;

    // Bus-cycle engine + chip model: logs triggers, answers reads 5 cycles later, CMR=04 releases RBS.
    initial begin : engine
        int         rd_cnt;
        int         a;
        logic [7:0] rd_resp;
        rd_cnt = 0;
        rd_resp = '0;
        sja.sja_rd_valid_i = 1'b0;
        sja.sja_rd_data_i  = '0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            sja.sja_rd_valid_i = 1'b0;
            if (!sys_rstn) rd_cnt = 0;
            else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    sja.sja_rd_valid_i = 1'b1;
                    sja.sja_rd_data_i  = rd_resp;
                end
            end
            if (sys_rstn && sja.sja_trig_o) begin
                log_cmd.push_back(sja.sja_cmd_o);
                log_cyc.push_back(cyc);
                a = int'(sja.sja_cmd_o[15:8]);
                if (!sja.sja_cmd_o[16]) begin
                    rd_cnt = 5;
                    if (a == 0) begin
                        if (mod_ones > 0) begin mod_ones--; rd_resp = 8'h01; end
                        else rd_resp = 8'h00;
                    end else if (a == 2) rd_resp = sr_val;
                    else if (a >= 16 && a < 32) rd_resp = rx_mem[a-16];
                    else rd_resp = 8'h00;
                end else if (sja.sja_cmd_o == 17'h10104) begin
                    sr_val[0] = 1'b0;
                    n_cmr4++;
                    cmr4_cyc = cyc;
                end
            end
            if (tx_ack) n_ack++;
            if (tx_done) begin
                n_done++;
                done_cyc = cyc;
                done_on_cmr = sja.sja_trig_o && (sja.sja_cmd_o == 17'h10101);
            end
            if (rx_valid) begin
                n_rxv++;
                rxv_cyc = cyc;
                cap_id = rx_id; cap_dlc = rx_dlc; cap_data = rx_data;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_init(input int budget);
        int k = 0;
        while (!init_done && k < budget) begin @(negedge sys_clk); k++; end
        checks++;
        if (init_done !== 1'b1) begin
            errors++; $display("FAIL init_timeout: init_done=%b want 1", init_done);
        end
    endtask

    task automatic tx_request(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        int k = 0;
        tx_id = id; tx_dlc = dlc; tx_data = data; tx_req = 1'b1;
        while (!tx_ack && k < 600) begin @(negedge sys_clk); k++; end
        checks++;
        if (tx_ack !== 1'b1) begin
            errors++; $display("FAIL tx_ack_timeout: tx_ack=%b want 1", tx_ack);
        end
        tx_req = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sys_clk);
        #1;
        checks++;
        if ({sja.sja_trig_o, sja.sja_cmd_o, init_done, tx_ack, tx_done, rx_valid} !== 22'd0) begin
            errors++;
            $display("FAIL reset_ctrl: trig=%b cmd=%h init=%b ack=%b done=%b rxv=%b want all 0",
                     sja.sja_trig_o, sja.sja_cmd_o, init_done, tx_ack, tx_done, rx_valid);
        end
        checks++;
        if ({rx_id, rx_dlc, rx_data} !== 79'd0) begin
            errors++; $display("FAIL reset_rx: id=%h dlc=%h data=%h want 0", rx_id, rx_dlc, rx_data);
        end
    endtask

    task automatic test_init;
        logic [16:0] exp[16];
        logic [16:0] got, m;
        exp = '{17'h10001, 17'h11FC8, 17'h10600, 17'h10714, 17'h1081A,
                17'h11000, 17'h11100, 17'h11200, 17'h11300,
                17'h114FF, 17'h115FF, 17'h116FF, 17'h117FF,
                17'h10400, 17'h10008, 17'h00000};
        log_cmd.delete(); log_cyc.delete();
        mod_ones = 0;
        @(negedge sys_clk); sys_rstn = 1'b1;
        wait_init(3000);
        checks++;
        if (log_cmd.size() != 16) begin
            errors++; $display("FAIL init_count: got %0d triggers want 16", log_cmd.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < log_cmd.size()) ? log_cmd[i] : 17'bx;
            m = exp[i][16] ? 17'h1FFFF : 17'h1FF00;
            checks++;
            if ((got & m) !== exp[i]) begin
                errors++; $display("FAIL init_cmd[%0d]: got %h want %h", i, got, exp[i]);
            end
        end
        for (int i = 1; i < 16 && i < log_cyc.size(); i++) begin
            checks++;
            if (log_cyc[i] - log_cyc[i-1] != ACC) begin
                errors++; $display("FAIL init_spacing[%0d]: got %0d want %0d", i, log_cyc[i] - log_cyc[i-1], ACC);
            end
        end
    endtask

    task automatic test_init_retry;
        logic [16:0] exp[4];
        logic [16:0] got, m;
        exp = '{17'h10008, 17'h00000, 17'h10008, 17'h00000};
        @(negedge sys_clk); sys_rstn = 1'b0;
        repeat (3) @(negedge sys_clk);
        log_cmd.delete(); log_cyc.delete();
        mod_ones = 1;
        sys_rstn = 1'b1;
        wait_init(3000);
        checks++;
        if (log_cmd.size() != 18) begin
            errors++; $display("FAIL retry_count: got %0d triggers want 18", log_cmd.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i + 14 < log_cmd.size()) ? log_cmd[i+14] : 17'bx;
            m = exp[i][16] ? 17'h1FFFF : 17'h1FF00;
            checks++;
            if ((got & m) !== exp[i]) begin
                errors++; $display("FAIL retry_cmd[%0d]: got %h want %h", i + 14, got, exp[i]);
            end
        end
    endtask

    task automatic test_tx;
        logic [16:0] exp[7];
        logic [16:0] got, m;
        int k = 0;
        exp = '{17'h00200, 17'h11002, 17'h11124, 17'h11260, 17'h113AA, 17'h114BB, 17'h10101};
        sr_val = 8'h04; n_ack = 0; n_done = 0;
        tx_request(11'h123, 4'd2, 64'hAABB_CCDD_EEFF_0011);
        log_cmd.delete(); log_cyc.delete();
        while (n_done == 0 && k < 1000) begin @(negedge sys_clk); k++; end
        for (int i = 0; i < 7; i++) begin
            got = (i < log_cmd.size()) ? log_cmd[i] : 17'bx;
            m = exp[i][16] ? 17'h1FFFF : 17'h1FF00;
            checks++;
            if ((got & m) !== exp[i]) begin
                errors++; $display("FAIL tx_cmd[%0d]: got %h want %h", i, got, exp[i]);
            end
        end
        checks++;
        if (done_on_cmr !== 1'b1) begin
            errors++; $display("FAIL tx_done_align: on_cmr_trigger=%b want 1", done_on_cmr);
        end
        repeat (150) @(negedge sys_clk);
        checks++;
        if (n_ack != 1 || n_done != 1) begin
            errors++; $display("FAIL tx_pulses: ack=%0d done=%0d want 1 1", n_ack, n_done);
        end
        sr_val = 8'h00;
    endtask

    task automatic test_rx_full;
        logic [16:0] e, got;
        int k = 0;
        rx_mem[0] = 8'h0F; rx_mem[1] = 8'hFF; rx_mem[2] = 8'hE0;
        for (int i = 0; i < 8; i++) rx_mem[3+i] = 8'(i + 1);
        n_rxv = 0;
        log_cmd.delete(); log_cyc.delete();
        sr_val = 8'h01;
        while (n_rxv == 0 && k < 1500) begin @(negedge sys_clk); k++; end
        checks++;
        if (cap_id !== 11'h7FF || cap_dlc !== 4'd8 || cap_data !== 64'h0102_0304_0506_0708) begin
            errors++; $display("FAIL rx_full: id=%h dlc=%h data=%h want 7ff 8 0102030405060708", cap_id, cap_dlc, cap_data);
        end
        for (int i = 0; i < 13; i++) begin
            if (i == 0)       e = 17'h00200;
            else if (i < 12)  e = {1'b0, 8'h0F + 8'(i), 8'h00};
            else              e = 17'h10104;
            got = (i < log_cmd.size()) ? log_cmd[i] : 17'bx;
            checks++;
            if ((got & (e[16] ? 17'h1FFFF : 17'h1FF00)) !== e) begin
                errors++; $display("FAIL rx_full_cmd[%0d]: got %h want %h", i, got, e);
            end
        end
        checks++;
        if (rxv_cyc - cmr4_cyc != 1) begin
            errors++; $display("FAIL rx_valid_align: got %0d cycles after CMR want 1", rxv_cyc - cmr4_cyc);
        end
    endtask

    task automatic test_rx_priority;
        logic [16:0] exp[14];
        logic [16:0] got, m;
        int k = 0;
        exp = '{17'h00200, 17'h01000, 17'h01100, 17'h01200, 17'h01300, 17'h01400, 17'h01500,
                17'h10104, 17'h00200, 17'h11001, 17'h111AA, 17'h112A0, 17'h1135A, 17'h10101};
        rx_mem[0] = 8'h03; rx_mem[1] = 8'h24; rx_mem[2] = 8'h60;
        rx_mem[3] = 8'h11; rx_mem[4] = 8'h22; rx_mem[5] = 8'h33;
        n_rxv = 0; n_done = 0;
        tx_request(11'h555, 4'd1, 64'h5A00_0000_0000_0000);
        log_cmd.delete(); log_cyc.delete();
        sr_val = 8'h05;
        while (n_done == 0 && k < 2000) begin @(negedge sys_clk); k++; end
        checks++;
        if (n_rxv != 1 || cap_id !== 11'h123 || cap_dlc !== 4'd3 || cap_data !== 64'h1122_3300_0000_0000) begin
            errors++;
            $display("FAIL rx_prio_frame: n=%0d id=%h dlc=%h data=%h want 1 123 3 1122330000000000",
                     n_rxv, cap_id, cap_dlc, cap_data);
        end
        checks++;
        if (!(rxv_cyc < done_cyc)) begin
            errors++; $display("FAIL rx_before_tx: rx_cycle=%0d tx_cycle=%0d want rx earlier", rxv_cyc, done_cyc);
        end
        for (int i = 0; i < 14; i++) begin
            got = (i < log_cmd.size()) ? log_cmd[i] : 17'bx;
            m = exp[i][16] ? 17'h1FFFF : 17'h1FF00;
            checks++;
            if ((got & m) !== exp[i]) begin
                errors++; $display("FAIL rx_prio_cmd[%0d]: got %h want %h", i, got, exp[i]);
            end
        end
        sr_val = 8'h00;
    endtask

    task automatic test_rx_ext;
        logic [16:0] exp[3];
        logic [16:0] got, m;
        int k = 0;
        exp = '{17'h00200, 17'h01000, 17'h10104};
        rx_mem[0] = 8'h88;
        n_rxv = 0; n_cmr4 = 0;
        log_cmd.delete(); log_cyc.delete();
        sr_val = 8'h01;
        while (n_cmr4 == 0 && k < 1500) begin @(negedge sys_clk); k++; end
        repeat (30) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            got = (i < log_cmd.size()) ? log_cmd[i] : 17'bx;
            m = exp[i][16] ? 17'h1FFFF : 17'h1FF00;
            checks++;
            if ((got & m) !== exp[i]) begin
                errors++; $display("FAIL rx_ext_cmd[%0d]: got %h want %h", i, got, exp[i]);
            end
        end
        checks++;
        if (n_rxv != 0 || rx_id !== 11'h123) begin
            errors++; $display("FAIL rx_ext_valid: pulses=%0d rx_id=%h want 0 123", n_rxv, rx_id);
        end
    endtask

    task automatic test_reset_mid_tx;
        int k = 0;
        sr_val = 8'h04; n_done = 0;
        tx_request(11'h123, 4'd2, 64'hAABB_0000_0000_0000);
        log_cmd.delete(); log_cyc.delete();
        while (log_cmd.size() < 3 && k < 1000) begin @(negedge sys_clk); k++; end
        checks++;
        if (log_cmd.size() < 3 || log_cmd[2] !== 17'h11124) begin
            errors++; $display("FAIL mid_tx_reach: got %0d triggers want addr17 write issued", log_cmd.size());
        end
        repeat (3) @(negedge sys_clk);
        sys_rstn = 1'b0;
        #1;
        checks++;
        if ({sja.sja_trig_o, sja.sja_cmd_o, init_done, rx_id, rx_dlc, rx_data} !== 97'd0) begin
            errors++;
            $display("FAIL mid_tx_reset_out: cmd=%h init=%b rx_id=%h want 0", sja.sja_cmd_o, init_done, rx_id);
        end
        repeat (3) @(negedge sys_clk);
        log_cmd.delete(); log_cyc.delete();
        sys_rstn = 1'b1;
        wait_init(3000);
        checks++;
        if (log_cmd.size() != 16 || log_cmd[0] !== 17'h10001) begin
            errors++; $display("FAIL mid_tx_reinit: got %0d triggers want 16 starting 10001", log_cmd.size());
        end
        repeat (200) @(negedge sys_clk);
        checks++;
        if (n_done != 0) begin
            errors++; $display("FAIL mid_tx_done: got %0d tx_done pulses want 0", n_done);
        end
        sr_val = 8'h00;
    endtask

    initial begin : main
        for (int i = 0; i < 16; i++) rx_mem[i] = 8'h00;
        test_reset();
        test_init();
        test_init_retry();
        test_tx();
        test_rx_full();
        test_rx_priority();
        test_rx_ext();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
